// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      WR_LO,
      WR_HI,
      DONE
   } mem_state_e;

   localparam int unsigned DATA_MEM_BASE = 1024;
   localparam int unsigned SRAM_DW       = 16;
   localparam int unsigned DATA_W        = 32;

   // 32-bit word index of a byte address relative to the data-memory base (wraps below base).
   function automatic logic [DATA_W-1:0] word_index(input logic [DATA_W-1:0] addr,
                                                    input logic [DATA_W-1:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side request/response and external 16-bit SRAM pins of the memory stage.
interface mem_stage_sram_ctrl_if #(
   parameter int unsigned SRAM_AW = 18
);
   logic                        mem_r_en;
   logic                        mem_w_en;
   logic [31:0]                 addr;
   logic [31:0]                 st_val;
   logic                        ready;
   logic [31:0]                 rdata;
   logic [SRAM_AW-1:0]          sram_addr;
   logic [mem_pkg::SRAM_DW-1:0] sram_wdata;
   logic [mem_pkg::SRAM_DW-1:0] sram_rdata;
   logic                        sram_we_n;
   logic                        sram_oe_n;

   // Environment side: pipeline register plus the SRAM device.
   modport master (
      output mem_r_en, mem_w_en, addr, st_val, sram_rdata,
      input  ready, rdata, sram_addr, sram_wdata, sram_we_n, sram_oe_n
   );

   // Controller side.
   modport slave (
      input  mem_r_en, mem_w_en, addr, st_val, sram_rdata,
      output ready, rdata, sram_addr, sram_wdata, sram_we_n, sram_oe_n
   );
endinterface

// File: rtl/mem_stage_sram_ctrl_phase_timer.sv
// Per-phase wait counter: load at phase entry, expire_c marks the last cycle of the phase.
module mem_phase_timer #(
   parameter int unsigned WAIT_CYCLES = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expire_c
);
   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // Down-counter, parked at zero once the phase has run out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (load)
         cnt_q <= LOAD_VAL;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - CNT_W'(1);
   end

   assign expire_c = (cnt_q == '0);
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage responder: 32-bit load/store as two 16-bit SRAM phases, stalling the pipeline.
// Optional statistics counters enabled by defining MEM_SRAM_STATS_EN.
module mem_stage_sram_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DATA_MEM_BASE,
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned WAIT_CYCLES = 1
)(
   input  logic clk,
   input  logic rst,
   mem_stage_sram_ctrl_if.slave bus
`ifdef MEM_SRAM_STATS_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic [31:0] stall_count
`endif
);
   localparam int unsigned IDX_W = SRAM_AW - 1;

   mem_state_e         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]  stv_q, stv_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
   logic [SRAM_DW-1:0] wdata_q, wdata_d;
   logic               we_n_q, we_n_d;
   logic               oe_n_q, oe_n_d;
   logic               timer_load;
   logic               expire_c;
   logic               ready_c;

   mem_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .expire_c (expire_c)
   );

   // Stall whenever a request is being accepted or a phase is in progress.
   assign ready_c = !(((state_q == IDLE) && (bus.mem_r_en || bus.mem_w_en)) ||
                      (state_q == RD_LO) || (state_q == RD_HI) ||
                      (state_q == WR_LO) || (state_q == WR_HI));

   // Next state, latched request, read capture and next SRAM pin values.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      stv_d       = stv_q;
      rdata_d     = rdata_q;
      timer_load  = 1'b0;
      sram_addr_d = sram_addr_q;
      wdata_d     = wdata_q;
      we_n_d      = 1'b1;
      oe_n_d      = 1'b1;

      case (state_q)
         IDLE: begin
            if (bus.mem_w_en || bus.mem_r_en) begin
               idx_d      = IDX_W'(word_index(bus.addr, DATA_W'(BASE_ADDR)));
               stv_d      = bus.st_val;
               timer_load = 1'b1;
               state_d    = bus.mem_w_en ? WR_LO : RD_LO;
            end
         end
         RD_LO: begin
            if (expire_c) begin
               rdata_d[15:0] = bus.sram_rdata;
               timer_load    = 1'b1;
               state_d       = RD_HI;
            end
         end
         RD_HI: begin
            if (expire_c) begin
               rdata_d[31:16] = bus.sram_rdata;
               state_d        = DONE;
            end
         end
         WR_LO: begin
            if (expire_c) begin
               timer_load = 1'b1;
               state_d    = WR_HI;
            end
         end
         WR_HI: begin
            if (expire_c)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Pins are registered from the upcoming state so they line up with it.
      case (state_d)
         RD_LO: begin
            sram_addr_d = {idx_d, 1'b0};
            oe_n_d      = 1'b0;
         end
         RD_HI: begin
            sram_addr_d = {idx_d, 1'b1};
            oe_n_d      = 1'b0;
         end
         WR_LO: begin
            sram_addr_d = {idx_d, 1'b0};
            wdata_d     = stv_d[15:0];
            we_n_d      = 1'b0;
         end
         WR_HI: begin
            sram_addr_d = {idx_d, 1'b1};
            wdata_d     = stv_d[31:16];
            we_n_d      = 1'b0;
         end
         default: ;
      endcase
   end

   // State and output registers; reset aborts any access with strobes released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         stv_q       <= '0;
         rdata_q     <= '0;
         sram_addr_q <= '0;
         wdata_q     <= '0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         stv_q       <= stv_d;
         rdata_q     <= rdata_d;
         sram_addr_q <= sram_addr_d;
         wdata_q     <= wdata_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
      end
   end

   assign bus.ready      = ready_c;
   assign bus.rdata      = rdata_q;
   assign bus.sram_addr  = sram_addr_q;
   assign bus.sram_wdata = wdata_q;
   assign bus.sram_we_n  = we_n_q;
   assign bus.sram_oe_n  = oe_n_q;

`ifdef MEM_SRAM_STATS_EN
   // Completed loads/stores and stalled cycles, all free-running with wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count    <= '0;
         wr_count    <= '0;
         stall_count <= '0;
      end else begin
         if ((state_q == RD_HI) && expire_c)
            rd_count <= rd_count + 32'd1;
         if ((state_q == WR_HI) && expire_c)
            wr_count <= wr_count + 32'd1;
         if (!ready_c)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif
endmodule
